// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin sharer of a one-cycle-latency SRAM with bounded burst lock
module sram_port_arbiter #(
  parameter int NumPorts  = 3,
  parameter int AddrWidth = 25,
  parameter int DataWidth = 64,
  parameter int MaxBurst  = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumPorts-1:0]                  req_i,
  input  logic [NumPorts-1:0]                  lock_i,
  input  logic [NumPorts-1:0]                  we_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]   addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]   wdata_i,
  input  logic [NumPorts-1:0][DataWidth/8-1:0] be_i,
  output logic [NumPorts-1:0]                  gnt_o,
  output logic [NumPorts-1:0]                  rvalid_o,
  output logic [DataWidth-1:0]                 rdata_o,
  output logic                                 sram_req_o,
  output logic                                 sram_we_o,
  output logic [AddrWidth-1:0]                 sram_addr_o,
  output logic [DataWidth-1:0]                 sram_wdata_o,
  output logic [DataWidth/8-1:0]               sram_be_o,
  input  logic [DataWidth-1:0]                 sram_rdata_i
);
  localparam int PW = $clog2(NumPorts);
  localparam int BW = MaxBurst > 1 ? $clog2(MaxBurst) : 1;
  logic [PW-1:0] rr_q, owner_q, sel, idx, nxt, owner_nxt;
  logic [BW-1:0] burst_q;
  logic [NumPorts-1:0] rvalid_q;
  logic locked_q, hold, any, keep;
  always_comb begin
    sel = '0;
    idx = '0;
    for (int i = NumPorts - 1; i >= 0; i--) begin
      idx = PW'((int'(rr_q) + i) % NumPorts);
      sel = req_i[idx] ? idx : sel;
    end
    hold = locked_q && req_i[owner_q];
    sel = hold ? owner_q : sel;
  end
  assign any          = rst_ni && |req_i;
  assign gnt_o        = any ? {{(NumPorts-1){1'b0}}, 1'b1} << sel : '0;
  assign keep         = MaxBurst > 1 && lock_i[sel] && (!hold || burst_q < BW'(MaxBurst - 1));
  assign nxt          = sel == PW'(NumPorts - 1) ? '0 : sel + 1'b1;
  assign owner_nxt    = owner_q == PW'(NumPorts - 1) ? '0 : owner_q + 1'b1;
  assign sram_req_o   = any;
  assign sram_we_o    = any && we_i[sel];
  assign sram_addr_o  = addr_i[sel];
  assign sram_wdata_o = wdata_i[sel];
  assign sram_be_o    = be_i[sel];
  assign rvalid_o     = rst_ni ? rvalid_q : '0;
  assign rdata_o      = sram_rdata_i;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q     <= '0;
      owner_q  <= '0;
      locked_q <= 1'b0;
      burst_q  <= '0;
      rvalid_q <= '0;
    end else begin
      rvalid_q <= gnt_o;
      if (any) begin
        locked_q <= keep;
        owner_q  <= keep ? sel : owner_q;
        burst_q  <= keep ? (hold ? burst_q + 1'b1 : BW'(1)) : '0;
        rr_q     <= keep ? rr_q : nxt;
      end else if (locked_q) begin
        locked_q <= 1'b0;
        burst_q  <= '0;
        rr_q     <= owner_nxt;
      end
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: scoreboard bench for sram_port_arbiter with a behavioural SRAM
module tb_sram_port_arbiter;
  localparam int N = 3, AW = 25, DW = 64, BE = 8;
  typedef struct packed {
    logic [N-1:0]  oh;
    logic          rd;
    logic [DW-1:0] data;
  } resp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req = '0, lock = '0, we = '0, gnt, rvalid;
  logic [N-1:0][AW-1:0] addr = '0;
  logic [N-1:0][DW-1:0] wdata = '0;
  logic [N-1:0][BE-1:0] be = '0;
  logic [DW-1:0] rdata, s_wdata, s_rdata = '0;
  logic [AW-1:0] s_addr;
  logic [BE-1:0] s_be;
  logic s_req, s_we;
  logic [DW-1:0] mem [256] = '{16: 64'hDEADBEEF_00000001, default: '0};
  logic [DW-1:0] exp_mem [256] = '{16: 64'hDEADBEEF_00000001, default: '0};
  resp_t q[$];
  int compared = 0, mismatched = 0;
  sram_port_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .lock_i(lock), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .be_i(be), .gnt_o(gnt), .rvalid_o(rvalid),
    .rdata_o(rdata), .sram_req_o(s_req), .sram_we_o(s_we), .sram_addr_o(s_addr),
    .sram_wdata_o(s_wdata), .sram_be_o(s_be), .sram_rdata_i(s_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (s_req && s_we) begin
      for (int b = 0; b < BE; b++)
        if (s_be[b]) mem[s_addr[7:0]][b*8 +: 8] <= s_wdata[b*8 +: 8];
    end else if (s_req) begin
      s_rdata <= mem[s_addr[7:0]];
    end
  end
  task automatic cycle(input logic [N-1:0] eg, input string name);
    resp_t r;
    int k;
    @(negedge clk);
    compared++;
    if (q.size() > 0) begin
      r = q.pop_front();
      if (rvalid !== r.oh || (r.rd && rdata !== r.data)) begin
        mismatched++;
        $display("FAIL %s resp: rvalid=%b rdata=%h, want rvalid=%b rdata=%h (rd=%b)", name, rvalid, rdata, r.oh, r.data, r.rd);
      end
    end else if (rvalid !== '0) begin
      mismatched++;
      $display("FAIL %s resp: rvalid=%b, want 000", name, rvalid);
    end
    compared++;
    if (gnt !== eg) begin
      mismatched++;
      $display("FAIL %s gnt: got %b want %b", name, gnt, eg);
    end
    compared++;
    if (eg != '0) begin
      k = 0;
      for (int i = 0; i < N; i++) if (eg[i]) k = i;
      if (s_req !== 1'b1 || s_we !== we[k] || s_addr !== addr[k] || (we[k] && (s_wdata !== wdata[k] || s_be !== be[k]))) begin
        mismatched++;
        $display("FAIL %s mux: req=%b we=%b addr=%h wdata=%h be=%h, want port %0d", name, s_req, s_we, s_addr, s_wdata, s_be, k);
      end
      r.oh = eg;
      r.rd = !we[k];
      r.data = exp_mem[addr[k][7:0]];
      if (we[k])
        for (int b = 0; b < BE; b++)
          if (be[k][b]) exp_mem[addr[k][7:0]][b*8 +: 8] = wdata[k][b*8 +: 8];
      q.push_back(r);
    end else if (s_req !== 1'b0 || s_we !== 1'b0) begin
      mismatched++;
      $display("FAIL %s idle: sram_req=%b sram_we=%b, want 0/0", name, s_req, s_we);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input string name);
    rst_n = 1'b0;
    @(negedge clk);
    compared++;
    if (gnt !== '0 || rvalid !== '0 || s_req !== 1'b0 || s_we !== 1'b0) begin
      mismatched++;
      $display("FAIL %s in reset: gnt=%b rvalid=%b sram_req=%b sram_we=%b, want all 0", name, gnt, rvalid, s_req, s_we);
    end
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    req = '1;
    we = '1;
    do_reset("reset0");
    rst_n = 1'b0;
    do_reset("reset1");
    req = '0;
    we = '0;
    cycle(3'b000, "reset_idle");
  endtask
  task automatic test_single();
    req = 3'b010;
    addr[1] = 25'h10;
    cycle(3'b010, "single_gnt");
    req = '0;
    cycle(3'b000, "single_resp");
  endtask
  task automatic test_round_robin();
    do_reset("rr_reset");
    req = 3'b111;
    addr[0] = 25'h10;
    addr[1] = 25'h5;
    addr[2] = 25'h7;
    for (int i = 0; i < 6; i++) cycle(3'b001 << (i % 3), "rr");
    req = '0;
    cycle(3'b000, "rr_drain");
  endtask
  task automatic test_lock_bound();
    do_reset("lock_reset");
    req = 3'b100;
    lock = 3'b100;
    cycle(3'b100, "lock_b1");
    req = 3'b111;
    for (int i = 0; i < 3; i++) cycle(3'b100, "lock_bn");
    cycle(3'b001, "lock_after0");
    cycle(3'b010, "lock_after1");
    req = '0;
    lock = '0;
    cycle(3'b000, "lock_drain");
  endtask
  task automatic test_early_release();
    do_reset("early_reset");
    req = 3'b001;
    lock = 3'b001;
    cycle(3'b001, "early_b1");
    cycle(3'b001, "early_b2");
    req = 3'b010;
    lock = '0;
    cycle(3'b010, "early_drop");
    req = 3'b101;
    cycle(3'b100, "early_p2");
    cycle(3'b001, "early_p0");
    req = '0;
    cycle(3'b000, "early_drain");
  endtask
  task automatic test_write_readback();
    req = 3'b001;
    we = 3'b001;
    addr[0] = 25'h5;
    wdata[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    be[0] = 8'h0F;
    cycle(3'b001, "wr");
    req = 3'b010;
    we = '0;
    addr[1] = 25'h5;
    cycle(3'b010, "rd_back");
    req = '0;
    cycle(3'b000, "rd_back_resp");
    compared++;
    if (exp_mem[5] !== 64'h0000_0000_FFFF_FFFF) begin
      mismatched++;
      $display("FAIL wr_model: got %h want 00000000ffffffff", exp_mem[5]);
    end
  endtask
  task automatic test_reset_mid_burst();
    req = 3'b010;
    lock = 3'b010;
    addr[1] = 25'h10;
    cycle(3'b010, "mid_b1");
    cycle(3'b010, "mid_b2");
    do_reset("mid_reset");
    req = 3'b011;
    lock = '0;
    cycle(3'b001, "mid_after0");
    cycle(3'b010, "mid_after1");
    req = '0;
    cycle(3'b000, "mid_drain");
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock_bound();
    test_early_release();
    test_write_readback();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
